// File: rtl/regfile_wb_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_sched_if
// Purpose  : Bundle of writeback-request, register-file write port and
//            issue/scoreboard query signals for regfile_wb_sched.
//            slave  = scheduler view, master = producer/issue-stage view.
// Revision : 1.0  initial release
// ============================================================================
interface regfile_wb_sched_if #(
  parameter int NUM_SRC = 3
);
  logic [NUM_SRC-1:0]    src_valid;
  logic [NUM_SRC-1:0]    src_ready;
  logic [5*NUM_SRC-1:0]  src_rd;
  logic [32*NUM_SRC-1:0] src_data;

  logic                  wb_wen;
  logic [4:0]            wb_rd;
  logic [31:0]           wb_data;

  logic                  issue_valid;
  logic [4:0]            issue_rd;
  logic                  issue_ready;

  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  fwd1_valid;
  logic                  fwd2_valid;
  logic [31:0]           fwd1_data;
  logic [31:0]           fwd2_data;

  modport slave (
    input  src_valid, src_rd, src_data, issue_valid, issue_rd, rs1, rs2,
    output src_ready, wb_wen, wb_rd, wb_data, issue_ready,
           rs1_busy, rs2_busy, fwd1_valid, fwd2_valid, fwd1_data, fwd2_data
  );

  modport master (
    output src_valid, src_rd, src_data, issue_valid, issue_rd, rs1, rs2,
    input  src_ready, wb_wen, wb_rd, wb_data, issue_ready,
           rs1_busy, rs2_busy, fwd1_valid, fwd2_valid, fwd1_data, fwd2_data
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_sched
// Purpose  : Round-robin writeback scheduler for the single register-file
//            write port, plus a 32-entry busy scoreboard used by the issue
//            stage to stall on RAW/WAW hazards.
// Options  : WB_FORWARD_EN - forward the in-flight writeback value to the
//            rs1/rs2 queries during the wb_wen cycle.
// Revision : 1.0  initial release
// ============================================================================
module regfile_wb_sched #(
  parameter int NUM_SRC = 3
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_sched_if.slave bus
);

  localparam int              PTR_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_SRC - 1);

  // Registered state
  logic [PTR_W-1:0]   ptr_q,     ptr_d;
  logic [31:0]        busy_q,    busy_d;
  logic               wb_wen_q,  wb_wen_d;
  logic [4:0]         wb_rd_q,   wb_rd_d;
  logic [31:0]        wb_data_q, wb_data_d;

  // Arbitration
  int                 arb_sum;
  logic [PTR_W-1:0]   arb_cand;
  logic               gnt_any;
  logic [PTR_W-1:0]   gnt_idx;
  logic               accept;
  logic [NUM_SRC-1:0] grant;
  logic [4:0]         sel_rd;
  logic [31:0]        sel_data;

  // Issue / forwarding
  logic               issue_rdy;
  logic               fwd1_hit;
  logic               fwd2_hit;

  // Search from the pointer upward (wrapping); the first requester found wins.
  always_comb begin
    arb_sum  = 0;
    arb_cand = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      arb_sum = int'(ptr_q) + k;
      if (arb_sum >= NUM_SRC) begin
        arb_sum = arb_sum - NUM_SRC;
      end
      arb_cand = arb_sum[PTR_W-1:0];
      if (!gnt_any && bus.src_valid[arb_cand]) begin
        gnt_any = 1'b1;
        gnt_idx = arb_cand;
      end
    end
  end

  // Decode the winner into a one-hot grant and select its rd/data.
  always_comb begin
    accept   = gnt_any && !rst;
    grant    = '0;
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int'(gnt_idx) == i) begin
        sel_rd   = bus.src_rd[i*5 +: 5];
        sel_data = bus.src_data[i*32 +: 32];
      end
    end
    if (accept) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  assign bus.src_ready = grant;

  // Next pointer and writeback register; rd=0 grants are consumed silently.
  always_comb begin
    ptr_d     = ptr_q;
    wb_wen_d  = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    if (accept) begin
      ptr_d     = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + PTR_W'(1);
      wb_wen_d  = (sel_rd != 5'd0);
      wb_rd_d   = sel_rd;
      wb_data_d = sel_data;
    end
  end

  assign issue_rdy       = !rst && !busy_q[bus.issue_rd];
  assign bus.issue_ready = issue_rdy;

  // Scoreboard: clear on commit first, then set on dispatch so set wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_wen_q) begin
      busy_d[wb_rd_q] = 1'b0;
    end
    if (bus.issue_valid && issue_rdy && (bus.issue_rd != 5'd0)) begin
      busy_d[bus.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State update with synchronous reset; a pending write is dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      busy_q    <= '0;
      wb_wen_q  <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      wb_wen_q  <= wb_wen_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign bus.wb_wen  = wb_wen_q;
  assign bus.wb_rd   = wb_rd_q;
  assign bus.wb_data = wb_data_q;

`ifdef WB_FORWARD_EN
  // The value being committed this cycle can satisfy a matching operand.
  always_comb begin
    fwd1_hit = !rst && wb_wen_q && (wb_rd_q == bus.rs1) && (bus.rs1 != 5'd0);
    fwd2_hit = !rst && wb_wen_q && (wb_rd_q == bus.rs2) && (bus.rs2 != 5'd0);
  end
`else
  // Forwarding disabled: operands wait for the scoreboard to clear.
  always_comb begin
    fwd1_hit = 1'b0;
    fwd2_hit = 1'b0;
  end
`endif

  // Operand busy query; x0 never busy, a forwarding hit removes the stall.
  always_comb begin
    bus.fwd1_valid = fwd1_hit;
    bus.fwd2_valid = fwd2_hit;
    bus.fwd1_data  = fwd1_hit ? wb_data_q : 32'd0;
    bus.fwd2_data  = fwd2_hit ? wb_data_q : 32'd0;
    bus.rs1_busy   = (bus.rs1 != 5'd0) && busy_q[bus.rs1] && !fwd1_hit;
    bus.rs2_busy   = (bus.rs2 != 5'd0) && busy_q[bus.rs2] && !fwd2_hit;
  end

endmodule
`default_nettype wire
